// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with frame-based debounce
module keypad_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE);

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } res_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_e;

    logic [3:0]    r_row_s1;
    logic [3:0]    r_row_s2;
    logic [SW-1:0] r_slot_cnt;
    logic [1:0]    r_col_idx;
    logic [1:0]    r_hits;
    logic [3:0]    r_first;
    res_e          r_prev_kind;
    logic [3:0]    r_prev_code;
    logic [DW-1:0] r_stable;
    state_e        r_state;
    logic [3:0]    r_key_code;
    logic          r_key_valid;

    logic          w_slot_last;
    logic          w_eval;
    logic [3:0]    w_pressed;
    logic [1:0]    w_hits_base;
    logic [2:0]    w_col_cnt;
    logic [2:0]    w_hits_sum;
    logic [1:0]    w_hits_new;
    logic [1:0]    w_lowest_row;
    logic [3:0]    w_first_new;
    res_e          w_res_kind;
    logic          w_same;
    logic [DW-1:0] w_stable_next;
    logic          w_debounced;
    state_e        w_state_next;
    logic [3:0]    w_code_next;
    logic          w_valid_next;

    // Two-flop synchronizer for the asynchronous row lines (idle = released)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_s1 <= 4'hF;
            r_row_s2 <= 4'hF;
        end else begin
            r_row_s1 <= row;
            r_row_s2 <= r_row_s1;
        end
    end

    assign w_slot_last = (r_slot_cnt == SLOT_LAST);
    assign w_eval      = w_slot_last && (r_col_idx == 2'd3);

    // Column slot timer; the column advances when the slot wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt <= '0;
            r_col_idx  <= 2'd0;
        end else if (w_slot_last) begin
            r_slot_cnt <= '0;
            r_col_idx  <= r_col_idx + 2'd1;
        end else begin
            r_slot_cnt <= r_slot_cnt + SW'(1);
        end
    end

    assign col = ~(4'b0001 << r_col_idx);

    // Per-column contribution: pressed count and lowest pressed row
    always_comb begin
        w_pressed    = ~r_row_s2;
        w_col_cnt    = {2'b00, w_pressed[0]} + {2'b00, w_pressed[1]}
                     + {2'b00, w_pressed[2]} + {2'b00, w_pressed[3]};
        w_lowest_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_pressed[i]) begin
                w_lowest_row = 2'(i);
            end
        end
        // Column 0 starts a new frame, so earlier accumulation is discarded
        w_hits_base = (r_col_idx == 2'd0) ? 2'd0 : r_hits;
        w_hits_sum  = {1'b0, w_hits_base} + w_col_cnt;
        w_hits_new  = (w_hits_sum >= 3'd2) ? 2'd2 : w_hits_sum[1:0];
        w_first_new = ((w_hits_base == 2'd0) && (w_col_cnt != 3'd0))
                    ? {r_col_idx, w_lowest_row} : r_first;
    end

    // Frame accumulators, updated at every column sample point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hits  <= 2'd0;
            r_first <= 4'h0;
        end else if (w_slot_last) begin
            r_hits  <= w_hits_new;
            r_first <= w_first_new;
        end
    end

    // Frame result classification and debounce stability tracking
    always_comb begin
        w_res_kind = RES_MULTI;
        if (w_hits_new == 2'd0) begin
            w_res_kind = RES_NONE;
        end else if (w_hits_new == 2'd1) begin
            w_res_kind = RES_SINGLE;
        end
        w_same = (w_res_kind == r_prev_kind)
              && ((w_res_kind != RES_SINGLE) || (w_first_new == r_prev_code));
        if (!w_same) begin
            w_stable_next = DW'(1);
        end else if (r_stable == DEB_MAX) begin
            w_stable_next = DEB_MAX;
        end else begin
            w_stable_next = r_stable + DW'(1);
        end
        // Only the frame where the count first lands on DEBOUNCE counts
        w_debounced = (w_stable_next == DEB_MAX) && !(w_same && (r_stable == DEB_MAX));
    end

    // Previous frame result and stability counter, updated once per frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_kind <= RES_NONE;
            r_prev_code <= 4'h0;
            r_stable    <= '0;
        end else if (w_eval) begin
            r_prev_kind <= w_res_kind;
            r_prev_code <= w_first_new;
            r_stable    <= w_stable_next;
        end
    end

    // Press/release FSM: next state and registered output values
    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_key_code;
        w_valid_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_eval && w_debounced && (w_res_kind == RES_SINGLE)) begin
                    w_state_next = ST_PRESSED;
                    w_code_next  = w_first_new;
                    w_valid_next = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (w_eval && w_debounced && (w_res_kind == RES_NONE)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_key_code  <= w_code_next;
            r_key_valid <= w_valid_next;
        end
    end

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = (r_state == ST_PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner
module tb_keypad_scanner;

    localparam int DIV = 4;
    localparam int DEB = 3;
    localparam int FRAME = 4 * DIV;

    logic       clk;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed;
    int          cyc;
    int          total;
    int          bad;
    int          pulse_cnt;
    int          last_code;
    int          last_pulse_cyc;

    typedef struct {
        int cyc;
        int code;
    } exp_t;
    exp_t exp_q[$];

    logic [15:0] m_fb;
    int          m_last;
    int          m_run;
    logic        m_held;
    int          m_code;

    keypad_scanner #(.SCAN_DIV(DIV), .DEBOUNCE(DEB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // keypad matrix: a row reads low if any pressed key on it sits in a driven column
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[4*c+r] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    // cycles since reset release; slot = cyc%DIV, column = (cyc/DIV)%4
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: snapshot each column's keys, classify whole frames,
    // accept when a result has repeated exactly DEB frames in a row
    always @(negedge clk) begin
        if (!rst_n) begin
            m_fb   <= '0;
            m_last <= 0;
            m_run  <= 0;
            m_held <= 1'b0;
            m_code <= 0;
            exp_q.delete();
        end else begin
            automatic logic [15:0] fb = m_fb;
            automatic int c = (cyc / DIV) % 4;
            automatic int cnt;
            automatic int low;
            automatic int res;
            automatic int run;
            if (cyc % DIV == 1) fb[4*c +: 4] = pressed[4*c +: 4];
            m_fb <= fb;
            if (cyc % FRAME == FRAME - 1) begin
                cnt = $countones(fb);
                low = 0;
                for (int b = 15; b >= 0; b--) if (fb[b]) low = b;
                res = (cnt == 0) ? 0 : (cnt == 1) ? low + 1 : 17;
                run = (res == m_last) ? m_run + 1 : 1;
                m_last <= res;
                m_run  <= run;
                if (!m_held && run == DEB && res >= 1 && res <= 16) begin
                    exp_q.push_back('{cyc + 1, res - 1});
                    m_held <= 1'b1;
                    m_code <= res - 1;
                end else if (m_held && run == DEB && res == 0) begin
                    m_held <= 1'b0;
                end
            end
        end
    end

    // monitor: compare DUT outputs against the model's expectations
    always @(negedge clk) begin
        if (rst_n) begin
            check("col_strobe", int'(col), int'(4'hF & ~(4'b0001 << ((cyc / DIV) % 4))));
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("missed_pulse", int'(key_valid), 1);
                void'(exp_q.pop_front());
            end
            if (key_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", int'(key_valid), 0);
                end else begin
                    check("pulse_cycle", cyc, exp_q[0].cyc);
                    check("pulse_code", int'(key_code), exp_q[0].code);
                    void'(exp_q.pop_front());
                end
                pulse_cnt      <= pulse_cnt + 1;
                last_code      <= int'(key_code);
                last_pulse_cyc <= cyc;
            end
            if (cyc % FRAME == 0) begin
                check("key_held", int'(key_held), int'(m_held));
                check("key_code", int'(key_code), m_code);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // assert reset shortly after an edge, check the async clear, release mid-cycle
    task automatic do_reset(input int hold);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_col", int'(col), 14);
        check("rst_valid", int'(key_valid), 0);
        check("rst_held", int'(key_held), 0);
        check("rst_code", int'(key_code), 0);
        repeat (hold) @(posedge clk);
        #7;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        automatic int p0;
        total = 0;
        bad = 0;
        pulse_cnt = 0;
        last_code = -1;
        last_pulse_cyc = -1;
        pressed = '0;
        rst_n = 1'b0;
        do_reset(3);

        // reset in the middle of a frame
        wait_cycles(2 * FRAME + 6);
        do_reset(2);
        wait_cycles(2 * FRAME);

        // clean press of key 9
        p0 = pulse_cnt;
        pressed = 16'h0001 << 9;
        wait_cycles(5 * FRAME);
        check("clean_pulses", pulse_cnt - p0, 1);
        check("clean_code", last_code, 9);
        check("clean_held", int'(key_held), 1);
        pressed = '0;
        wait_cycles(5 * FRAME);

        // bouncing contact on key 3, then steady
        p0 = pulse_cnt;
        for (int i = 0; i < 8; i++) begin
            pressed[3] = ~pressed[3];
            wait_cycles(5);
        end
        pressed[3] = 1'b1;
        wait_cycles(5 * FRAME);
        check("bounce_pulses", pulse_cnt - p0, 1);
        check("bounce_code", last_code, 3);

        // release
        p0 = pulse_cnt;
        pressed = '0;
        wait_cycles(5 * FRAME);
        check("release_held", int'(key_held), 0);
        check("release_code", int'(key_code), 3);
        check("release_pulses", pulse_cnt - p0, 0);

        // two keys together from idle
        p0 = pulse_cnt;
        pressed = (16'h0001 << 1) | (16'h0001 << 14);
        wait_cycles(10 * FRAME);
        check("multi_pulses", pulse_cnt - p0, 0);
        check("multi_held", int'(key_held), 0);

        // no rollover: add a second key while one is held
        pressed = 16'h0001 << 5;
        wait_cycles(5 * FRAME);
        p0 = pulse_cnt;
        pressed[10] = 1'b1;
        wait_cycles(5 * FRAME);
        check("rollover_pulses", pulse_cnt - p0, 0);
        check("rollover_held", int'(key_held), 1);
        check("rollover_code", int'(key_code), 5);
        pressed = '0;
        wait_cycles(4 * FRAME);
        check("both_release_held", int'(key_held), 0);

        // reset while a key is still held
        pressed = 16'h0001 << 15;
        wait_cycles(5 * FRAME);
        check("pre_reset_held", int'(key_held), 1);
        p0 = pulse_cnt;
        do_reset(2);
        wait_cycles(5 * FRAME);
        check("rstpress_pulses", pulse_cnt - p0, 1);
        check("rstpress_code", last_code, 15);
        check("rstpress_cycle", last_pulse_cyc, 3 * FRAME);

        // random press patterns and durations
        for (int i = 0; i < 30; i++) begin
            automatic int sel = $urandom_range(0, 3);
            case (sel)
                0: pressed = '0;
                1, 2: pressed = 16'h0001 << $urandom_range(0, 15);
                default: pressed = (16'h0001 << $urandom_range(0, 15))
                                 | (16'h0001 << $urandom_range(0, 15));
            endcase
            wait_cycles($urandom_range(1, 6 * FRAME));
        end

        pressed = '0;
        wait_cycles(6 * FRAME);
        check("final_held", int'(key_held), 0);
        check("pending_pulses", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
